// File: rtl/serial_to_parallel_idle_rx_pkg.sv
// Shared constants and state encoding for the serial IDLE receiver.
// Used by serial_to_parallel_idle_rx and symbol_align_fsm.
package pcie_phy_pkg;

  localparam logic [7:0] COM_SYM_DEF  = 8'hBC;
  localparam logic [7:0] IDLE_SYM_DEF = 8'h7C;

  localparam int BIT_CNT_W  = 3;
  localparam int COM_CNT_W  = 4;
  localparam int MISALIGN_W = 2;

  localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = 3'd7;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } align_state_t;

  // MSB-first deserialiser step: oldest bit falls off the top.
  function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
    return {sr[6:0], b};
  endfunction

endpackage

// File: rtl/serial_to_parallel_idle_rx_symbol_align_fsm.sv
// Byte-alignment state machine: finds COM, counts aligned COMs to lock.
// With RX_RESYNC_EN, repeated misaligned COMs while locked drop the lock.
module symbol_align_fsm
  import pcie_phy_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int MISALIGN_MAX = 2
) (
  input  logic clk32f,
  input  logic reset,
  input  logic i_win_is_com,
  output logic o_active,
  output logic o_byte_strobe
);

  localparam logic [COM_CNT_W-1:0] LOCK_TARGET = COM_CNT_W'(LOCK_COUNT);

  align_state_t         r_state;
  align_state_t         w_state_next;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [BIT_CNT_W-1:0] w_bit_cnt_next;
  logic [COM_CNT_W-1:0] r_com_cnt;
  logic [COM_CNT_W-1:0] w_com_cnt_next;
  logic                 w_boundary;

  assign w_boundary = (r_bit_cnt == BIT_CNT_LAST);

`ifdef RX_RESYNC_EN
  localparam logic [MISALIGN_W-1:0] MISALIGN_LIMIT = MISALIGN_W'(MISALIGN_MAX);

  logic [MISALIGN_W-1:0] r_misalign_cnt;
  logic [MISALIGN_W-1:0] w_misalign_cnt_next;

  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) begin
      r_misalign_cnt <= '0;
    end else begin
      r_misalign_cnt <= w_misalign_cnt_next;
    end
  end
`else
  logic w_unused_misalign;
  assign w_unused_misalign = (MISALIGN_MAX != 0);
`endif

  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) begin
      r_state   <= SEARCH;
      r_bit_cnt <= '0;
      r_com_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_com_cnt <= w_com_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt + 1'b1;
    w_com_cnt_next = r_com_cnt;
`ifdef RX_RESYNC_EN
    w_misalign_cnt_next = r_misalign_cnt;
`endif
    case (r_state)
      SEARCH: begin
        // A COM anywhere defines the phase: the next boundary is 8 edges away.
        if (i_win_is_com) begin
          w_bit_cnt_next = '0;
          w_com_cnt_next = COM_CNT_W'(1);
          w_state_next   = (LOCK_TARGET == COM_CNT_W'(1)) ? LOCKED : LOCKING;
        end
      end
      LOCKING: begin
        if (w_boundary) begin
          if (i_win_is_com) begin
            w_com_cnt_next = r_com_cnt + 1'b1;
            if (r_com_cnt + 1'b1 == LOCK_TARGET) begin
              w_state_next = LOCKED;
            end
          end else begin
            w_com_cnt_next = '0;
            w_state_next   = SEARCH;
          end
        end
      end
      LOCKED: begin
`ifdef RX_RESYNC_EN
        if (w_boundary) begin
          if (i_win_is_com) begin
            w_misalign_cnt_next = '0;
          end
        end else if (i_win_is_com) begin
          if (r_misalign_cnt + 1'b1 == MISALIGN_LIMIT) begin
            w_state_next        = SEARCH;
            w_com_cnt_next      = '0;
            w_misalign_cnt_next = '0;
          end else begin
            w_misalign_cnt_next = r_misalign_cnt + 1'b1;
          end
        end
`endif
      end
      default: begin
        w_state_next   = SEARCH;
        w_com_cnt_next = '0;
      end
    endcase
  end

  assign o_active      = (r_state == LOCKED);
  assign o_byte_strobe = (r_state == LOCKED) && w_boundary;

endmodule

// File: rtl/serial_to_parallel_idle_rx.sv
// MSB-first serial receiver: aligns on COM, then strobes each byte and flags COM/IDLE.
// Optional macro RX_RESYNC_EN lets misaligned COMs drop lock (inside symbol_align_fsm).
module serial_to_parallel_idle_rx
  import pcie_phy_pkg::*;
#(
  parameter logic [7:0] COM_SYM      = COM_SYM_DEF,
  parameter logic [7:0] IDLE_SYM     = IDLE_SYM_DEF,
  parameter int         LOCK_COUNT   = 4,
  parameter int         MISALIGN_MAX = 2
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic       in,
  output logic       active,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       is_com,
  output logic       is_idle
);

  logic [7:0] r_shift_reg;
  logic [7:0] w_win;
  logic       w_win_is_com;
  logic       w_active;
  logic       w_byte_strobe;

  logic [7:0] r_data_out;
  logic       r_valid_out;
  logic       r_is_com;
  logic       r_is_idle;

  // The window includes the bit being sampled this edge, so a byte completes
  // on the same edge its last bit arrives.
  assign w_win        = shift_in(r_shift_reg, in);
  assign w_win_is_com = (w_win == COM_SYM);

  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) begin
      r_shift_reg <= '0;
    end else begin
      r_shift_reg <= w_win;
    end
  end

  symbol_align_fsm #(
    .LOCK_COUNT   (LOCK_COUNT),
    .MISALIGN_MAX (MISALIGN_MAX)
  ) u_align (
    .clk32f        (clk32f),
    .reset         (reset),
    .i_win_is_com  (w_win_is_com),
    .o_active      (w_active),
    .o_byte_strobe (w_byte_strobe)
  );

  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_is_com    <= 1'b0;
      r_is_idle   <= 1'b0;
    end else begin
      r_valid_out <= w_byte_strobe;
      if (w_byte_strobe) begin
        r_data_out <= w_win;
        r_is_com   <= w_win_is_com;
        r_is_idle  <= (w_win == IDLE_SYM);
      end
    end
  end

  assign active    = w_active;
  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign is_com    = r_is_com;
  assign is_idle   = r_is_idle;

endmodule

// File: tb/tb_serial_to_parallel_idle_rx.sv
// Scoreboard bench for serial_to_parallel_idle_rx: a bit-stream model predicts
// lock timing and byte strobes; a monitor checks the DUT every cycle.
module tb_serial_to_parallel_idle_rx;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;
  localparam int LOCK_N  = 4;
  localparam int MIS_MAX = 2;
  localparam int MAX_BITS = 8192;

  logic       clk32f = 1'b0;
  logic       reset  = 1'b1;
  logic       in     = 1'b0;
  logic       active;
  logic [7:0] data_out;
  logic       valid_out;
  logic       is_com;
  logic       is_idle;

  always #5 clk32f = ~clk32f;

  serial_to_parallel_idle_rx dut (
    .clk32f    (clk32f),
    .reset     (reset),
    .in        (in),
    .active    (active),
    .data_out  (data_out),
    .valid_out (valid_out),
    .is_com    (is_com),
    .is_idle   (is_idle)
  );

  typedef struct {
    int         t;
    logic [7:0] b;
  } exp_t;

  int         total = 0;
  int         bad   = 0;
  bit         stim[$];
  exp_t       expq[$];
  bit         exp_active[MAX_BITS];
  int         cur_t = 0;
  int         mode  = 0;  // 0: in reset, 1: running a segment, 2: between segments
  logic [7:0] hold_b = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, cur_t, act, req);
    end
  endtask

  function automatic logic [7:0] win_at(input int t);
    logic [7:0] w;
    w = 8'h00;
    for (int i = t - 7; i <= t; i++) begin
      w = {w[6:0], (i >= 0) ? stim[i] : 1'b0};
    end
    return w;
  endfunction

  // Reference: scan the bit history. Find a COM, demand LOCK_N COMs spaced by
  // 8 bits, then every 8th window after the lock point is a delivered byte.
  task automatic build_model();
    int n, t, s, e, fail_at, lk, mis, lost;
    n = stim.size();
    expq.delete();
    for (int i = 0; i < MAX_BITS; i++) exp_active[i] = 1'b0;
    t = 0;
    while (t < n) begin
      s = t;
      while (s < n && win_at(s) != COM) s++;
      if (s >= n) break;
      fail_at = -1;
      for (int k = 1; k < LOCK_N; k++) begin
        e = s + 8 * k;
        if (e >= n) begin fail_at = n; break; end
        if (win_at(e) != COM) begin fail_at = e; break; end
      end
      if (fail_at >= 0) begin
        t = fail_at + 1;
        continue;
      end
      lk = s + 8 * (LOCK_N - 1);
      mis = 0;
      lost = -1;
      for (int j = lk; j < n; j++) begin
        exp_active[j] = 1'b1;
        if (j > lk && (j - lk) % 8 == 0) begin
          expq.push_back('{t: j, b: win_at(j)});
          if (win_at(j) == COM) mis = 0;
        end else if (j > lk && win_at(j) == COM) begin
`ifdef RX_RESYNC_EN
          mis++;
          if (mis == MIS_MAX) begin
            exp_active[j] = 1'b0;
            lost = j;
            break;
          end
`endif
        end
      end
      if (lost < 0) break;
      t = lost + 1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) stim.push_back(b[i]);
  endtask

  task automatic push_rand_bits(input int nb);
    for (int i = 0; i < nb; i++) stim.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_active"}, 32'(active), 0);
    check({tag, "_valid"}, 32'(valid_out), 0);
    check({tag, "_data"}, 32'(data_out), 0);
    check({tag, "_is_com"}, 32'(is_com), 0);
    check({tag, "_is_idle"}, 32'(is_idle), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a byte.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk32f);
      #1;
      if (mode == 0) begin
        check_all_zero("in_reset");
      end else if (mode == 1) begin
        check("active", 32'(active), 32'(exp_active[cur_t]));
        if (valid_out) begin
          if (expq.size() == 0) begin
            check("strobe_unexpected", 32'(valid_out), 0);
          end else begin
            e = expq.pop_front();
            check("strobe_time", 32'(cur_t), 32'(e.t));
            check("data_out", 32'(data_out), 32'(e.b));
            check("is_com", 32'(is_com), 32'(e.b == COM));
            check("is_idle", 32'(is_idle), 32'(e.b == IDLE));
            hold_b = e.b;
          end
        end else begin
          if (expq.size() > 0 && expq[0].t <= cur_t) begin
            check("strobe_missing", 32'(valid_out), 1);
            void'(expq.pop_front());
          end
          check("data_hold", 32'(data_out), 32'(hold_b));
        end
      end
    end
  end

  // Each segment starts from a held reset and ends with an async reset
  // asserted between edges, so partial bytes are cut off mid-stream.
  task automatic run_segment(input string name);
    mode = 0;
    repeat (5) begin
      @(negedge clk32f);
      in = 1'($urandom_range(0, 1));
    end
    build_model();
    hold_b = 8'h00;
    $display("segment %s: %0d bits, %0d strobes expected", name, stim.size(), expq.size());
    for (int t = 0; t < stim.size(); t++) begin
      @(negedge clk32f);
      if (t == 0) reset = 1'b0;
      cur_t = t;
      in = stim[t];
      mode = 1;
    end
    @(negedge clk32f);
    mode = 2;
    #2 reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    check("scoreboard_drained", 32'(expq.size()), 0);
    stim.delete();
  endtask

  task automatic random_byte_mix(input int nbytes);
    int r;
    for (int i = 0; i < nbytes; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) push_byte(COM);
      else if (r < 6) push_byte(IDLE);
      else if (r < 9) push_byte(8'($urandom()));
      else push_rand_bits(int'($urandom_range(1, 7)));
    end
  endtask

  initial begin
    logic [7:0] quiet [4];
    quiet[0] = 8'h00; quiet[1] = 8'hFF; quiet[2] = 8'h55; quiet[3] = 8'hAA;

    // No COM ever appears: everything stays at zero.
    for (int i = 0; i < 8; i++) push_byte(quiet[$urandom_range(0, 3)]);
    run_segment("no_com");

    // Basic lock and symbol flagging.
    push_rand_bits(3);
    repeat (LOCK_N) push_byte(COM);
    push_byte(8'h55);
    push_byte(IDLE); push_byte(COM); push_byte(IDLE);
    for (int i = 0; i < 8; i++) push_byte(8'($urandom()));
    run_segment("lock_basic");

    // A bad byte during LOCKING restarts the search.
    push_rand_bits(3);
    push_byte(COM); push_byte(COM); push_byte(8'h00);
    repeat (LOCK_N) push_byte(COM);
    push_byte(8'h55); push_byte(IDLE);
    for (int i = 0; i < 4; i++) push_byte(8'($urandom()));
    run_segment("locking_abort");

    // Locked stream cut by reset at bit 3 of a byte.
    push_rand_bits(3);
    repeat (LOCK_N) push_byte(COM);
    for (int i = 0; i < 6; i++) push_byte(8'($urandom()));
    push_rand_bits(3);
    run_segment("reset_mid_byte");

    // Phase slip by 3 bits with misaligned COMs, then relock at the new phase.
    push_rand_bits(3);
    repeat (LOCK_N) push_byte(COM);
    push_byte(8'h55); push_byte(IDLE);
    push_rand_bits(3);
    push_byte(IDLE); push_byte(COM); push_byte(IDLE); push_byte(COM); push_byte(IDLE);
    repeat (LOCK_N) push_byte(COM);
    push_byte(8'h55); push_byte(8'hA5); push_byte(IDLE);
    push_rand_bits(3);
    run_segment("phase_slip");

    for (int k = 0; k < 3; k++) begin
      push_rand_bits(int'($urandom_range(0, 7)));
      repeat (LOCK_N) push_byte(COM);
      random_byte_mix(40);
      run_segment("random_mix");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_idle_rx.md
Name: serial_to_parallel_idle_rx

Overview:
- Receive end of the PCIe-style serial link: deserialises the MSB-first bit stream produced by the parallel-to-serial IDLE transmitter.
- Finds byte alignment from the COM symbol (0xBC) and raises `active` once the link is locked.
- After lock, delivers aligned bytes with a one-cycle strobe and flags COM and IDLE (0x7C) symbols.
- Sits between the serial channel and the byte-striping/demux logic in the clk32f domain.

Parameters:
- COM_SYM, 8'hBC, comma/alignment symbol.
- IDLE_SYM, 8'h7C, idle symbol.
- LOCK_COUNT, 4, consecutive aligned COMs required to assert `active` (range 1..15).
- MISALIGN_MAX, 2, misaligned COMs that force loss of lock (used only with the optional feature).

Ports:
- clk32f  in  1  bit clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in  in  1  serial data, MSB first, sampled every rising clk32f.
- active  out  1  link locked.
- data_out  out  8  last aligned byte.
- valid_out  out  1  one-cycle strobe: data_out updated.
- is_com  out  1  data_out == COM_SYM; qualified by valid_out.
- is_idle  out  1  data_out == IDLE_SYM; qualified by valid_out.

Behaviour:
- Reset (async, reset=1):
  - shift_reg=0, bit_cnt=0, com_cnt=0, state=SEARCH.
  - All outputs 0 (active=0, data_out=8'h00, valid_out=0, is_com=0, is_idle=0).
  - Reset asserted mid-byte discards the partial byte and any lock; alignment restarts from SEARCH after release.
- Shift: every edge, shift_reg <= {shift_reg[6:0], in}. win = {shift_reg[6:0], in} is the combinational 8-bit window including the current bit.
- bit_cnt: 3-bit, increments every edge, wraps 7->0. A byte boundary is the edge where bit_cnt==7 in LOCKING/LOCKED.
- SEARCH:
  - Every edge, compare win to COM_SYM.
  - On match: bit_cnt<=0, com_cnt<=1. If LOCK_COUNT==1 go to LOCKED, else go to LOCKING.
  - No outputs strobe.
- LOCKING, on boundary edges only:
  - win==COM_SYM: com_cnt++. When com_cnt reaches LOCK_COUNT, go to LOCKED and set active<=1 on the same edge.
  - Any other byte: com_cnt<=0, go to SEARCH (the search window resumes on the next edge).
- LOCKED, on each boundary edge (registered, visible the cycle after the last bit is sampled):
  - data_out<=win, valid_out<=1.
  - is_com<=(win==COM_SYM), is_idle<=(win==IDLE_SYM).
  - valid_out is 0 on all other edges; data_out, is_com and is_idle hold their values.
- The COM that completes lock is not strobed. The first valid_out comes 8 cycles after active rises.
- Latency: last bit of a byte sampled at edge N; data_out/valid_out are valid after edge N (one register stage). Byte rate is one strobe per 8 clk32f cycles.
- Without the optional feature, LOCKED persists until reset; active stays 1.

Optional Feature:
- Macro: RX_RESYNC_EN.
- With the macro:
  - In LOCKED, a win==COM_SYM on a non-boundary edge increments the 2-bit misalign_cnt.
  - An aligned COM clears misalign_cnt.
  - When misalign_cnt reaches MISALIGN_MAX: go to SEARCH, active<=0, com_cnt<=0, misalign_cnt<=0, no strobe that cycle.
  - If a boundary edge and a misaligned match coincide, that is impossible by definition. If a boundary COM arrives in the same cycle the limit would be hit, the aligned COM wins.
- Without the macro: misalign_cnt is absent and misaligned COM patterns are ignored.

Decomposition:
- Package pcie_phy_pkg: COM_SYM/IDLE_SYM default constants, state encoding typedef (SEARCH=2'd0, LOCKING=2'd1, LOCKED=2'd2), bit-count width.
- One natural sub-module: symbol_align_fsm (state, bit_cnt, com_cnt, optional misalign_cnt). Shift register and output registers stay in the top module.

Test Plan:
- Reset held 5 cycles with random `in` -> active=0, valid_out=0, data_out=8'h00 throughout; release and no COM for 64 cycles -> still all 0.
- 3 garbage bits, then 4x 0xBC MSB-first -> active rises on the last bit of the 4th COM. Next byte 0x55 -> valid_out=1 for one cycle 8 cycles later, data_out=8'h55, is_com=0, is_idle=0.
- After lock, stream 0x7C,0xBC,0x7C -> three strobes spaced exactly 8 cycles apart with (is_idle,is_com) = (1,0),(0,1),(1,0).
- During LOCKING, 2x 0xBC then 0x00 -> back to SEARCH. 4 further COMs are needed; active rises only after the 4th.
- Locked stream with reset pulsed mid-byte (bit 3) -> outputs 0 immediately (asynchronously); relock requires 4 fresh aligned COMs.
- RX_RESYNC_EN: locked, then inject the stream shifted by 3 bits containing 2 COMs -> active drops after the 2nd misaligned COM. 4 COMs at the new phase relock; data_out reflects the new alignment. Without the macro, the same stimulus leaves active=1.
